line_mem_ctrl: RTL and testbench

- Parametrised line-granular backing memory for the data cache's memory-side port (enable/write/ack handshake).
- Successor to the fixed 256-bit, 512-entry, fixed-delay data memory.
- Line width, depth, address width and access latency are all parameters.
- Adds an explicit busy indication and a strictly defined one-cycle ack pulse.
- Sits between the CPU's dcache and the top level; replaces the old memory instance in the CPU test bench.

---
 rtl/line_mem_ctrl.sv | 135 +++++++++++++
 tb/tb_line_mem_ctrl.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_ctrl.sv
// Line-granular backing memory for the dcache memory port.
// Optional saturating access counters: define LINE_MEM_STATS_EN.
module line_mem_ctrl #(
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 32,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o,
    output logic              busy_o
`ifdef LINE_MEM_STATS_EN
    ,
    output logic [31:0]       rd_count_o,
    output logic [31:0]       wr_count_o
`endif
);
    localparam int OFFSET = $clog2(LINE_W / 8);
    localparam int IDX_W  = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACK} state_t;

    state_t            state_q;
    logic [7:0]        cnt_q;
    logic [IDX_W-1:0]  idx_q;
    logic              wr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              ack_q;
    logic              busy_q;
    logic [LINE_W-1:0] rdata_q;
    logic [LINE_W-1:0] mem_q [DEPTH];

    logic [IDX_W-1:0]  in_idx;
    logic [IDX_W-1:0]  acc_idx;
    logic              acc_wr;
    logic [LINE_W-1:0] acc_data;
    logic              go_ack;
    logic              unused_addr;

    assign in_idx      = addr_i[OFFSET+IDX_W-1:OFFSET];
    assign unused_addr = ^addr_i;

    // With LATENCY=1 the access completes on the accepting edge,
    // so it must use the live inputs rather than the latched copy.
    assign acc_idx  = (state_q == IDLE) ? in_idx   : idx_q;
    assign acc_wr   = (state_q == IDLE) ? write_i  : wr_q;
    assign acc_data = (state_q == IDLE) ? data_i   : wdata_q;

    assign go_ack = ((state_q == IDLE) && enable_i && (LATENCY == 1))
                 || ((state_q == WAIT) && (cnt_q == 8'd1));

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            ack_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (enable_i) begin
                        idx_q   <= in_idx;
                        wr_q    <= write_i;
                        wdata_q <= data_i;
                        cnt_q   <= 8'(LATENCY - 1);
                        busy_q  <= 1'b1;
                        state_q <= (LATENCY == 1) ? ACK : WAIT;
                    end
                end
                WAIT: begin
                    cnt_q <= cnt_q - 8'd1;
                    if (cnt_q == 8'd1) begin
                        state_q <= ACK;
                    end
                end
                ACK: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
            if (go_ack) begin
                ack_q <= 1'b1;
                if (!acc_wr) begin
                    rdata_q <= mem_q[acc_idx];
                end
            end
        end
    end

    // Array has no reset; gating on rst_i drops writes while held in reset.
    always_ff @(posedge clk_i) begin
        if (rst_i && go_ack && acc_wr) begin
            mem_q[acc_idx] <= acc_data;
        end
    end

    assign ack_o  = ack_q;
    assign busy_o = busy_q;
    assign data_o = rdata_q;

`ifdef LINE_MEM_STATS_EN
    logic [31:0] rd_cnt_q;
    logic [31:0] wr_cnt_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else if (go_ack) begin
            if (acc_wr) begin
                if (wr_cnt_q != 32'hFFFF_FFFF) begin
                    wr_cnt_q <= wr_cnt_q + 32'd1;
                end
            end else if (rd_cnt_q != 32'hFFFF_FFFF) begin
                rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign rd_count_o = rd_cnt_q;
    assign wr_count_o = wr_cnt_q;
`endif
endmodule

// File: tb/tb_line_mem_ctrl.sv
// Bench for line_mem_ctrl: default build and a LATENCY=1, 128-bit build.
// Stats counters are checked when LINE_MEM_STATS_EN is defined.
module tb_line_mem_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n;
    logic [31:0]  addr_a, addr_b;
    logic [255:0] wd_a;
    logic [127:0] wd_b;
    logic         en_a, en_b, we_a, we_b;
    logic         ack_a, ack_b, busy_a, busy_b;
    logic [255:0] rd_a;
    logic [127:0] rd_b;
`ifdef LINE_MEM_STATS_EN
    logic [31:0]  rc_a, wc_a, rc_b, wc_b;
`endif

    line_mem_ctrl u_a (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr_a), .data_i(wd_a),
        .enable_i(en_a), .write_i(we_a), .ack_o(ack_a), .data_o(rd_a),
        .busy_o(busy_a)
`ifdef LINE_MEM_STATS_EN
        , .rd_count_o(rc_a), .wr_count_o(wc_a)
`endif
    );

    line_mem_ctrl #(.LINE_W(128), .DEPTH(16), .ADDR_W(32), .LATENCY(1)) u_b (
        .clk_i(clk), .rst_i(rst_n), .addr_i(addr_b), .data_i(wd_b),
        .enable_i(en_b), .write_i(we_b), .ack_o(ack_b), .data_o(rd_b),
        .busy_o(busy_b)
`ifdef LINE_MEM_STATS_EN
        , .rd_count_o(rc_b), .wr_count_o(wc_b)
`endif
    );

    int tests = 0;
    int fails = 0;

    // Reference model: line contents keyed by (dut, line index)
    logic [255:0] mdl [int];
    logic [255:0] last [2];
    int           rds [2];
    int           wrs [2];
    logic [31:0]  wq0 [$];
    logic [31:0]  wq1 [$];

    function automatic int lat_of(input int d);
        return (d == 0) ? 10 : 1;
    endfunction

    function automatic int idx_of(input int d, input logic [31:0] a);
        return (d == 0) ? int'((a / 32) % 512) : int'((a / 16) % 16);
    endfunction

    function automatic int key(input int d, input int idx);
        return d * 1024 + idx;
    endfunction

    function automatic logic [255:0] rand_line(input int d);
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        if (d == 1) v[255:128] = '0;
        return v;
    endfunction

    function automatic logic get_ack(input int d);
        return (d == 0) ? ack_a : ack_b;
    endfunction

    function automatic logic get_busy(input int d);
        return (d == 0) ? busy_a : busy_b;
    endfunction

    function automatic logic [255:0] get_rd(input int d);
        return (d == 0) ? rd_a : {128'b0, rd_b};
    endfunction

    task automatic drive(input int d, input logic en, input logic we,
                         input logic [31:0] a, input logic [255:0] w);
        if (d == 0) begin
            en_a = en; we_a = we; addr_a = a; wd_a = w;
        end else begin
            en_b = en; we_b = we; addr_b = a; wd_b = w[127:0];
        end
    endtask

    task automatic check(input string tag, input logic [255:0] obs,
                         input logic [255:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        last[0] = '0; last[1] = '0;
        rds[0] = 0; rds[1] = 0;
        wrs[0] = 0; wrs[1] = 0;
    endtask

    task automatic access(input int d, input logic wr, input logic [31:0] a,
                          input logic [255:0] wdata);
        int lat;
        int k;
        logic [255:0] w;
        w = (d == 1) ? {128'b0, wdata[127:0]} : wdata;
        @(negedge clk);
        drive(d, 1'b1, wr, a, w);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'($urandom), $urandom, rand_line(d));
        lat = 1;
        while (!get_ack(d) && lat < 300) begin
            check("busy_wait", 256'(get_busy(d)), 256'(1));
            check("data_hold", get_rd(d), last[d]);
            @(posedge clk); #1;
            lat++;
        end
        check("ack_seen", 256'(get_ack(d)), 256'(1));
        check("latency", 256'(lat), 256'(lat_of(d)));
        check("busy_ack", 256'(get_busy(d)), 256'(1));
        k = key(d, idx_of(d, a));
        if (wr) begin
            mdl[k] = w;
            wrs[d]++;
            if (d == 0) wq0.push_back(a); else wq1.push_back(a);
        end else begin
            last[d] = mdl[k];
            rds[d]++;
        end
        check(wr ? "data_after_wr" : "data_rd", get_rd(d), last[d]);
        @(posedge clk); #1;
        check("ack_pulse", 256'(get_ack(d)), 256'(0));
        check("busy_idle", 256'(get_busy(d)), 256'(0));
    endtask

    initial begin
        int lat, gap, d;
        logic [255:0] w3, w7, old5;
        logic [31:0] a;

        rst_n = 1'b0;
        drive(0, 1'b0, 1'b0, '0, '0);
        drive(1, 1'b0, 1'b0, '0, '0);
        clear_model();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ack_a", 256'(ack_a), 256'(0));
        check("rst_busy_a", 256'(busy_a), 256'(0));
        check("rst_data_a", rd_a, 256'(0));
        check("rst_ack_b", 256'(ack_b), 256'(0));
        check("rst_busy_b", 256'(busy_b), 256'(0));
        check("rst_data_b", get_rd(1), 256'(0));
        rst_n = 1'b1;

        // Preload line 0 with 5, then read, alias and offset-bit reads
        access(0, 1'b1, 32'h0, 256'd5);
        access(0, 1'b0, 32'h0, '0);
        check("rd0_value", rd_a, 256'd5);
        access(0, 1'b1, 32'h400, 256'hDEADBEEF);
        access(0, 1'b0, 32'h400, '0);
        check("rd400_value", rd_a, 256'hDEADBEEF);
        access(0, 1'b0, 32'h4000, '0);
        check("alias4000", rd_a, 256'd5);
        access(0, 1'b0, 32'h1F, '0);

        // Write-back to line 3 followed at once by an allocate of line 7
        w7 = rand_line(0);
        access(0, 1'b1, 32'hE0, w7);
        w3 = rand_line(0);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'h60, w3);
        @(posedge clk); #1;
        lat = 1;
        while (!ack_a && lat < 300) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b2b_wr_ack", 256'(ack_a), 256'(1));
        check("b2b_wr_lat", 256'(lat), 256'(10));
        we_a = 1'b0; addr_a = 32'hE0; wd_a = rand_line(0);
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
            if (gap == 2) en_a = 1'b0;
        end while (!ack_a && gap < 300);
        check("b2b_rd_ack", 256'(ack_a), 256'(1));
        check("b2b_gap", 256'(gap), 256'(11));
        check("b2b_rd_data", rd_a, w7);
        mdl[key(0, 3)] = w3;
        wq0.push_back(32'h60);
        wrs[0]++; rds[0]++; last[0] = w7;
        @(posedge clk); #1;
        check("b2b_idle", 256'(busy_a), 256'(0));
        access(0, 1'b0, 32'h60, '0);

        // Reset during WAIT of a write to line 5 discards that write
        old5 = rand_line(0);
        access(0, 1'b1, 32'hA0, old5);
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 32'hA0, rand_line(0));
        @(posedge clk); #1;
        en_a = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrst_ack", 256'(ack_a), 256'(0));
        check("midrst_busy", 256'(busy_a), 256'(0));
        check("midrst_data", rd_a, 256'(0));
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'hA0, '0);
        check("line5_kept", rd_a, old5);

        // LATENCY=1, 128-bit build: 2 writes and 3 reads
        access(1, 1'b1, 32'h20, rand_line(1));
        access(1, 1'b1, 32'h90, rand_line(1));
        access(1, 1'b0, 32'h20, '0);
        access(1, 1'b0, 32'h9F, '0);
        access(1, 1'b0, 32'h120, '0);
`ifdef LINE_MEM_STATS_EN
        check("rd_count_b", 256'(rc_b), 256'(rds[1]));
        check("wr_count_b", 256'(wc_b), 256'(wrs[1]));
`endif

        // Randomised mixed traffic on both builds
        for (int r = 0; r < 40; r++) begin
            d = int'($urandom_range(0, 1));
            if (($urandom % 2) == 0) begin
                access(d, 1'b1, $urandom, rand_line(d));
            end else if (d == 0) begin
                a = wq0[$urandom_range(0, wq0.size() - 1)];
                a = {$urandom_range(0, 15), a[13:5], 5'($urandom)};
                access(0, 1'b0, a, '0);
            end else begin
                a = wq1[$urandom_range(0, wq1.size() - 1)];
                a = {$urandom_range(0, 15), a[7:4], 4'($urandom)};
                access(1, 1'b0, a, '0);
            end
        end
`ifdef LINE_MEM_STATS_EN
        check("rd_count_a", 256'(rc_a), 256'(rds[0]));
        check("wr_count_a", 256'(wc_a), 256'(wrs[0]));
        check("rd_count_b_end", 256'(rc_b), 256'(rds[1]));
        check("wr_count_b_end", 256'(wc_b), 256'(wrs[1]));
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
